fetch_sequencer: RTL

//  Drives the PC and IR program_registers: reads current PC, issues a memory read with

---
 rtl/fetch_sequencer_if.sv | 29 ++
 rtl/fetch_sequencer.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer_if.sv
// rtl/fetch_sequencer_if.sv - instruction memory read request/response bus
interface fetch_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             mem_req_valid;
    logic             mem_req_ready;
    logic [WIDTH-1:0] mem_req_addr;
    logic             mem_rsp_valid;
    logic [WIDTH-1:0] mem_rsp_data;
    logic             mem_rsp_err;

    modport master (
        output mem_req_valid,
        output mem_req_addr,
        input  mem_req_ready,
        input  mem_rsp_valid,
        input  mem_rsp_data,
        input  mem_rsp_err
    );

    modport slave (
        input  mem_req_valid,
        input  mem_req_addr,
        output mem_req_ready,
        output mem_rsp_valid,
        output mem_rsp_data,
        output mem_rsp_err
    );
endinterface

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - PC/IR fetch sequencer with single outstanding memory read
// Optional WAIT-state timeout fault enabled by defining FETCH_TIMEOUT_EN.
module fetch_sequencer #(
    parameter int WIDTH          = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              redirect_valid,
    input  logic [WIDTH-1:0]  redirect_pc,
    input  logic [WIDTH-1:0]  pc_q,
    output logic              pc_load,
    output logic [WIDTH-1:0]  pc_d,
    output logic              ir_load,
    output logic [WIDTH-1:0]  ir_d,
    output logic              done,
    output logic              busy,
    output logic              fault,
    fetch_sequencer_if.master mem
);
    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_WAIT, S_COMMIT, S_REDIR, S_FAULT
    } state_t;

    state_t           r_state;
    logic             r_req_valid;
    logic [WIDTH-1:0] r_addr;
    logic [WIDTH-1:0] r_pc_d;
    logic [WIDTH-1:0] r_ir_d;
    logic             r_pc_load;
    logic             r_ir_load;
    logic             r_done;
    logic             r_busy;
    logic             r_fault;
    logic             r_redir_pend;
    logic [WIDTH-1:0] r_redir_pc;

    // A redirect arriving in the same cycle as the response still discards it.
    logic             w_pend;
    logic [WIDTH-1:0] w_target;
    assign w_pend   = r_redir_pend | redirect_valid;
    assign w_target = redirect_valid ? redirect_pc : r_redir_pc;

`ifdef FETCH_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] r_tmo;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_req_valid  <= 1'b0;
            r_addr       <= '0;
            r_pc_d       <= '0;
            r_ir_d       <= '0;
            r_pc_load    <= 1'b0;
            r_ir_load    <= 1'b0;
            r_done       <= 1'b0;
            r_busy       <= 1'b0;
            r_fault      <= 1'b0;
            r_redir_pend <= 1'b0;
            r_redir_pc   <= '0;
`ifdef FETCH_TIMEOUT_EN
            r_tmo        <= '0;
`endif
        end else begin
            r_pc_load <= 1'b0;
            r_ir_load <= 1'b0;
            r_done    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (redirect_valid) begin
                        r_state   <= S_REDIR;
                        r_busy    <= 1'b1;
                        r_pc_load <= 1'b1;
                        r_pc_d    <= redirect_pc;
                    end else if (start) begin
                        r_busy <= 1'b1;
                        if (pc_q[1:0] == 2'b00) begin
                            r_state     <= S_REQ;
                            r_req_valid <= 1'b1;
                            r_addr      <= pc_q;
                        end else begin
                            r_state <= S_FAULT;
                            r_fault <= 1'b1;
                        end
                    end
                end
                S_REQ: begin
                    if (redirect_valid) begin
                        r_redir_pend <= 1'b1;
                        r_redir_pc   <= redirect_pc;
                    end
                    if (mem.mem_req_ready) begin
                        r_req_valid <= 1'b0;
                        r_state     <= S_WAIT;
`ifdef FETCH_TIMEOUT_EN
                        r_tmo       <= '0;
`endif
                    end
                end
                S_WAIT: begin
                    if (redirect_valid) begin
                        r_redir_pend <= 1'b1;
                        r_redir_pc   <= redirect_pc;
                    end
                    if (mem.mem_rsp_valid) begin
                        r_redir_pend <= 1'b0;
                        r_state      <= S_COMMIT;
                        if (w_pend) begin
                            r_pc_load <= 1'b1;
                            r_pc_d    <= w_target;
                        end else if (mem.mem_rsp_err) begin
                            r_state <= S_FAULT;
                            r_fault <= 1'b1;
                        end else begin
                            r_ir_d    <= mem.mem_rsp_data;
                            r_ir_load <= 1'b1;
                            r_pc_load <= 1'b1;
                            r_pc_d    <= r_addr + WIDTH'(4);
                            r_done    <= 1'b1;
                        end
                    end else begin
`ifdef FETCH_TIMEOUT_EN
                        if (r_tmo == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                            r_state      <= S_FAULT;
                            r_fault      <= 1'b1;
                            r_redir_pend <= 1'b0;
                        end else begin
                            r_tmo <= r_tmo + TMO_W'(1);
                        end
`endif
                    end
                end
                S_COMMIT, S_REDIR: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                S_FAULT: begin
                    if (redirect_valid) begin
                        r_state   <= S_REDIR;
                        r_fault   <= 1'b0;
                        r_pc_load <= 1'b1;
                        r_pc_d    <= redirect_pc;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign pc_load           = r_pc_load;
    assign pc_d              = r_pc_d;
    assign ir_load           = r_ir_load;
    assign ir_d              = r_ir_d;
    assign done              = r_done;
    assign busy              = r_busy;
    assign fault             = r_fault;
    assign mem.mem_req_valid = r_req_valid;
    assign mem.mem_req_addr  = r_addr;
endmodule
